key_bank_ctrl: RTL and testbench

Sequencing controller between the matrix keypad and the 16×3 colour register bank. It turns raw key activity into debounced, one-shot read-modify-write operations: each press advances the stored colour of the pressed cell by one. It also performs a full-bank clear sweep on request. The read address is time-shared with the VGA scanner, and the block drives the buzzer tone value and beep window for the PWM.

---
 rtl/key_bank_ctrl_if.sv | 15 +
 rtl/key_bank_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_key_bank_ctrl.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/key_bank_ctrl_if.sv
// Colour register bank port bundle: one combinational read port and one write port.
// The controller is the master; the bank is the slave.
interface key_bank_ctrl_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 3
);
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (output rd_addr, wr_en, wr_addr, wr_data, input rd_data);
    modport slave  (input rd_addr, wr_en, wr_addr, wr_data, output rd_data);
endinterface

// File: rtl/key_bank_ctrl.sv
// Keypad-to-colour-bank sequencer: debounced one-shot read-modify-write per press,
// full-bank clear sweep, VGA read-port sharing and buzzer tone/beep window.
module key_bank_ctrl #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 3,
    parameter int DEB_CYCLES  = 50000,
    parameter int BEEP_CYCLES = 5000000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_opr,
    input  logic [ADDR_W-1:0]   key_pos,
    input  logic                clr_req,
    input  logic [ADDR_W-1:0]   vga_addr,
    key_bank_ctrl_if.master     bank,
    output logic                vga_valid,
    output logic                beep,
    output logic [11:0]         tone_n,
    output logic                busy,
    output logic                clr_done
);
    localparam int CNT_W  = $clog2(DEB_CYCLES + 1);
    localparam int BCNT_W = $clog2(BEEP_CYCLES + 1);
    localparam logic [CNT_W-1:0]  DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = CNT_W'(1'b0);
    localparam logic [BCNT_W-1:0] BEEP_LOAD = BCNT_W'(BEEP_CYCLES);
    localparam logic [BCNT_W-1:0] BEEP_ONE  = BCNT_W'(1'b1);
    localparam logic [BCNT_W-1:0] BEEP_ZERO = BCNT_W'(1'b0);
    localparam logic [DATA_W-1:0] DATA_ONE  = DATA_W'(1'b1);
    localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(1'b0);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1'b1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(1'b0);
    localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
    localparam logic [11:0]       TONE_BASE = 12'd1000;
    localparam logic [11:0]       TONE_STEP = 12'd50;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DEBOUNCE = 3'd1,
        ST_READ     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_HOLD     = 3'd4,
        ST_CLEAR    = 3'd5
    } state_t;

    state_t              state_r, state_s;
    logic                sync1_r, key_s_r;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [ADDR_W-1:0]   pos_r, pos_s;
    logic [ADDR_W-1:0]   clr_addr_r, clr_addr_s;
    logic                clr_pend_r, clr_pend_s;
    logic [BCNT_W-1:0]   beep_cnt_r, beep_cnt_s;
    logic                wr_en_r, wr_en_s;
    logic [ADDR_W-1:0]   wr_addr_r, wr_addr_s;
    logic [DATA_W-1:0]   wr_data_r, wr_data_s;
    logic                beep_r;
    logic [11:0]         tone_r;
    logic                load_tone_s;
    logic                clr_fin_r, clr_fin_s;
    logic                clr_done_r;

    // Two-flop synchronizer for the asynchronous keypad flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            key_s_r <= 1'b0;
        end else begin
            sync1_r <= key_opr;
            key_s_r <= sync1_r;
        end
    end

    // Next-state, counters and write-port requests; outputs are registered below.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        pos_s       = pos_r;
        clr_addr_s  = clr_addr_r;
        clr_pend_s  = clr_pend_r | (clr_req & (state_r != ST_IDLE));
        wr_en_s     = 1'b0;
        wr_addr_s   = wr_addr_r;
        wr_data_s   = wr_data_r;
        load_tone_s = 1'b0;
        clr_fin_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (clr_pend_r || clr_req) begin
                    clr_addr_s = ADDR_ZERO;
                    state_s    = ST_CLEAR;
                end else if (key_s_r) begin
                    pos_s   = key_pos;
                    cnt_s   = CNT_ZERO;
                    state_s = ST_DEBOUNCE;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DEBOUNCE: begin
                if (!key_s_r) begin
                    state_s = ST_IDLE;
                end else if (key_pos != pos_r) begin
                    pos_s = key_pos;
                    cnt_s = CNT_ZERO;
                end else if (cnt_r == DEB_LAST) begin
                    state_s = ST_READ;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            // The write strobe is requested here so the registered wr_en is high during WRITE.
            ST_READ: begin
                wr_en_s   = 1'b1;
                wr_addr_s = pos_r;
                wr_data_s = bank.rd_data + DATA_ONE;
                state_s   = ST_WRITE;
            end
            ST_WRITE: begin
                load_tone_s = 1'b1;
                cnt_s       = CNT_ZERO;
                state_s     = ST_HOLD;
            end
            ST_HOLD: begin
                if (key_s_r) begin
                    cnt_s = CNT_ZERO;
                end else if (cnt_r == DEB_LAST) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_CLEAR: begin
                wr_en_s   = 1'b1;
                wr_addr_s = clr_addr_r;
                wr_data_s = DATA_ZERO;
                if (clr_addr_r == ADDR_LAST) begin
                    clr_fin_s  = 1'b1;
                    clr_pend_s = 1'b0;
                    state_s    = ST_IDLE;
                end else begin
                    clr_addr_s = clr_addr_r + ADDR_ONE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        if (load_tone_s) begin
            beep_cnt_s = BEEP_LOAD;
        end else if (beep_cnt_r != BEEP_ZERO) begin
            beep_cnt_s = beep_cnt_r - BEEP_ONE;
        end else begin
            beep_cnt_s = BEEP_ZERO;
        end
    end

    // State and sequencing registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            pos_r      <= ADDR_ZERO;
            clr_addr_r <= ADDR_ZERO;
            clr_pend_r <= 1'b0;
            beep_cnt_r <= BEEP_ZERO;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            pos_r      <= pos_s;
            clr_addr_r <= clr_addr_s;
            clr_pend_r <= clr_pend_s;
            beep_cnt_r <= beep_cnt_s;
        end
    end

    // Registered outputs; clr_done trails the final sweep write by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_en_r    <= 1'b0;
            wr_addr_r  <= ADDR_ZERO;
            wr_data_r  <= DATA_ZERO;
            beep_r     <= 1'b0;
            tone_r     <= TONE_BASE;
            clr_fin_r  <= 1'b0;
            clr_done_r <= 1'b0;
        end else begin
            wr_en_r    <= wr_en_s;
            wr_addr_r  <= wr_addr_s;
            wr_data_r  <= wr_data_s;
            beep_r     <= (beep_cnt_s != BEEP_ZERO);
            tone_r     <= load_tone_s ? (TONE_BASE + 12'(pos_r) * TONE_STEP) : tone_r;
            clr_fin_r  <= clr_fin_s;
            clr_done_r <= clr_fin_r;
        end
    end

    assign bank.rd_addr = (state_r == ST_READ) ? pos_r : vga_addr;
    assign bank.wr_en   = wr_en_r;
    assign bank.wr_addr = wr_addr_r;
    assign bank.wr_data = wr_data_r;
    assign vga_valid    = (state_r != ST_READ);
    assign busy         = (state_r != ST_IDLE);
    assign beep         = beep_r;
    assign tone_n       = tone_r;
    assign clr_done     = clr_done_r;
endmodule

// File: tb/tb_key_bank_ctrl.sv
// Directed bench for key_bank_ctrl with a behavioural 16x3 colour bank.
module tb_key_bank_ctrl;
    localparam int AW = 4;
    localparam int DW = 3;

    logic        clk = 1'b0;
    logic        rst, key_opr, clr_req;
    logic [3:0]  key_pos, vga_addr;
    logic        vga_valid, beep, busy, clr_done;
    logic [11:0] tone_n;

    int errors = 0;
    int checks = 0;

    logic [2:0] bank [16] = '{default: 3'd0};
    int nw = 0, nvl = 0, nbp = 0, ndone = 0, cyc = 0, done_cyc = 0;
    logic [3:0] wa [256];
    logic [2:0] wd [256];
    int         wc [256];

    key_bank_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
    assign bus.rd_data = bank[bus.rd_addr];

    key_bank_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DEB_CYCLES(4), .BEEP_CYCLES(10)) dut (
        .clk(clk), .rst(rst), .key_opr(key_opr), .key_pos(key_pos), .clr_req(clr_req),
        .vga_addr(vga_addr), .bank(bus.master), .vga_valid(vga_valid), .beep(beep),
        .tone_n(tone_n), .busy(busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    // Bank model plus event log sampled at each rising edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.wr_en === 1'b1) begin
            bank[bus.wr_addr] <= bus.wr_data;
            wa[nw] <= bus.wr_addr;
            wd[nw] <= bus.wr_data;
            wc[nw] <= cyc;
            nw     <= nw + 1;
        end
        if (vga_valid === 1'b0) nvl <= nvl + 1;
        if (beep === 1'b1) nbp <= nbp + 1;
        if (clr_done === 1'b1) begin
            ndone    <= ndone + 1;
            done_cyc <= cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; key_opr = 1'b0; key_pos = 4'd0; clr_req = 1'b0; vga_addr = 4'd7;
        tick(3);
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, beep, busy, clr_done, vga_valid}
            !== {1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_ctrl: got %b_%h_%h_%b%b%b%b want 0_0_0_0001", bus.wr_en, bus.wr_addr,
                     bus.wr_data, beep, busy, clr_done, vga_valid);
        end
        checks++;
        if (tone_n !== 12'd1000) begin
            errors++; $display("FAIL reset_tone: got %0d want 1000", tone_n);
        end
        checks++;
        if (bus.rd_addr !== 4'd7) begin
            errors++; $display("FAIL reset_rd_addr: got %0d want 7", bus.rd_addr);
        end
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_single_press();
        int w0, v0, b0, first;
        w0 = nw; v0 = nvl; b0 = nbp; first = -1;
        key_pos = 4'd5; key_opr = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (bus.wr_en === 1'b1 && first < 0) first = k;
        end
        key_opr = 1'b0;
        tick(12);
        checks++;
        if (nw - w0 !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", nw - w0); end
        checks++;
        if ({wa[w0], wd[w0]} !== {4'd5, 3'd1}) begin
            errors++; $display("FAIL single_write: got addr %0d data %0d want addr 5 data 1", wa[w0], wd[w0]);
        end
        checks++;
        if (first !== 8) begin errors++; $display("FAIL single_latency: got %0d want 8", first); end
        checks++;
        if (nvl - v0 !== 1) begin errors++; $display("FAIL single_vga_loss: got %0d want 1", nvl - v0); end
        checks++;
        if (nbp - b0 !== 10) begin errors++; $display("FAIL single_beep_len: got %0d want 10", nbp - b0); end
        checks++;
        if (tone_n !== 12'd1250) begin errors++; $display("FAIL single_tone: got %0d want 1250", tone_n); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got busy %b want 0", busy); end
    endtask

    task automatic test_repeat_wrap();
        int w0;
        logic [2:0] exp_d;
        w0 = nw;
        for (int n = 0; n < 8; n++) begin
            key_pos = 4'd9; key_opr = 1'b1;
            tick(6);
            key_opr = 1'b0;
            tick(6);
        end
        tick(4);
        checks++;
        if (nw - w0 !== 8) begin errors++; $display("FAIL repeat_count: got %0d want 8", nw - w0); end
        for (int i = 0; i < 8; i++) begin
            exp_d = 3'(i + 1);
            checks++;
            if ({wa[w0 + i], wd[w0 + i]} !== {4'd9, exp_d}) begin
                errors++;
                $display("FAIL repeat_data%0d: got addr %0d data %0d want addr 9 data %0d",
                         i, wa[w0 + i], wd[w0 + i], exp_d);
            end
        end
    endtask

    task automatic test_glitch_and_pos_change();
        int w0;
        w0 = nw;
        key_pos = 4'd1; key_opr = 1'b1;
        tick(3);
        key_opr = 1'b0;
        tick(10);
        checks++;
        if (nw - w0 !== 0) begin errors++; $display("FAIL glitch_writes: got %0d want 0", nw - w0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL glitch_idle: got busy %b want 0", busy); end
        w0 = nw;
        key_pos = 4'd3; key_opr = 1'b1;
        tick(4);
        key_pos = 4'd4;
        tick(16);
        key_opr = 1'b0;
        tick(10);
        checks++;
        if (nw - w0 !== 1) begin errors++; $display("FAIL poschg_count: got %0d want 1", nw - w0); end
        checks++;
        if ({wa[w0], wd[w0]} !== {4'd4, 3'd1}) begin
            errors++; $display("FAIL poschg_write: got addr %0d data %0d want addr 4 data 1", wa[w0], wd[w0]);
        end
        checks++;
        if (bank[3] !== 3'd0) begin errors++; $display("FAIL poschg_addr3: got %0d want 0", bank[3]); end
    endtask

    task automatic test_clear_pending();
        int w0, v0, d0, j;
        w0 = nw; v0 = nvl; d0 = ndone;
        key_pos = 4'd2; key_opr = 1'b1;
        tick(12);
        clr_req = 1'b1;
        tick(1);
        clr_req = 1'b0;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL pend_hold_busy: got %b want 1", busy); end
        tick(4);
        key_opr = 1'b0;
        tick(40);
        checks++;
        if (nw - w0 !== 17) begin errors++; $display("FAIL pend_count: got %0d want 17", nw - w0); end
        for (int i = 0; i < 16; i++) begin
            j = w0 + 1 + i;
            checks++;
            if (wa[j] !== 4'(i) || wd[j] !== 3'd0 || wc[j] !== wc[w0 + 1] + i) begin
                errors++;
                $display("FAIL pend_sweep%0d: got addr %0d data %0d cyc %0d want addr %0d data 0 cyc %0d",
                         i, wa[j], wd[j], wc[j], i, wc[w0 + 1] + i);
            end
        end
        checks++;
        if (ndone - d0 !== 1) begin errors++; $display("FAIL pend_done_count: got %0d want 1", ndone - d0); end
        checks++;
        if (done_cyc !== wc[w0 + 16] + 1) begin
            errors++; $display("FAIL pend_done_time: got %0d want %0d", done_cyc, wc[w0 + 16] + 1);
        end
        checks++;
        if (nvl - v0 !== 1) begin errors++; $display("FAIL pend_vga_loss: got %0d want 1", nvl - v0); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bank[i] !== 3'd0) begin errors++; $display("FAIL pend_bank%0d: got %0d want 0", i, bank[i]); end
        end
    endtask

    task automatic test_clear_and_key();
        int w0;
        w0 = nw;
        key_pos = 4'd6; key_opr = 1'b1;
        tick(2);
        clr_req = 1'b1;
        tick(1);
        clr_req = 1'b0;
        tick(40);
        key_opr = 1'b0;
        tick(10);
        checks++;
        if (nw - w0 !== 17) begin errors++; $display("FAIL both_count: got %0d want 17", nw - w0); end
        checks++;
        if ({wa[w0], wa[w0 + 15]} !== {4'd0, 4'd15}) begin
            errors++; $display("FAIL both_clear_first: got %0d..%0d want 0..15", wa[w0], wa[w0 + 15]);
        end
        checks++;
        if ({wa[w0 + 16], wd[w0 + 16]} !== {4'd6, 3'd1}) begin
            errors++;
            $display("FAIL both_key_after: got addr %0d data %0d want addr 6 data 1", wa[w0 + 16], wd[w0 + 16]);
        end
    endtask

    task automatic test_reset_mid_clear();
        int w0;
        bit found;
        w0 = nw; found = 1'b0;
        clr_req = 1'b1;
        tick(1);
        clr_req = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.wr_en === 1'b1 && bus.wr_addr === 4'd6) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (found !== 1'b1) begin errors++; $display("FAIL midrst_reach6: got %b want 1", found); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.wr_en, bus.wr_addr, bus.wr_data, beep, busy, clr_done, vga_valid}
            !== {1'b0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL midrst_ctrl: got %b_%h_%h_%b%b%b%b want 0_0_0_0001", bus.wr_en, bus.wr_addr,
                     bus.wr_data, beep, busy, clr_done, vga_valid);
        end
        checks++;
        if (tone_n !== 12'd1000) begin errors++; $display("FAIL midrst_tone: got %0d want 1000", tone_n); end
        tick(2);
        rst = 1'b1;
        tick(30);
        checks++;
        if (nw - w0 !== 7) begin errors++; $display("FAIL midrst_writes: got %0d want 7", nw - w0); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_repeat_wrap();
        test_glitch_and_pos_change();
        test_clear_pending();
        test_clear_and_key();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
